// File: rtl/control_sequencer.sv
// Hardwired control unit for the DataPath: fetch (T0-T2) and register-to-register
// ALU execute (T3-T6), with Moore-decoded strobes and a sticky HALT state.
module control_sequencer #(
  parameter int NREG = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     IR,
  input  logic            MemReady,
  input  logic            Stop,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            HIin,
  output logic            LOin,
  output logic            Read,
  output logic [4:0]      opcode,
  output logic            Run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t state_q, state_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_bin, is_md, is_un, is_halt;
  logic       unused_ir;
  state_t     nxt_t0;

  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  // Binary ALU ops occupy one contiguous code range (add..shl).
  assign is_bin  = (op >= OP_ADD) && (op <= OP_SHL);
  assign is_md   = (op == OP_MUL) || (op == OP_DIV);
  assign is_un   = (op == OP_NEG) || (op == OP_NOT);
  assign is_halt = (op == OP_HALT);

  // Stop only diverts the edge that would start a new instruction.
  assign nxt_t0 = Stop ? S_HALT : S_T0;

  function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
    logic [NREG-1:0] f;
    f = '0;
    for (int i = 0; i < NREG; i++) f[i] = (32'(idx) == i);
    return f;
  endfunction

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    Rin      = '0;
    Rout     = '0;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Read     = 1'b0;
    opcode   = 5'b00000;
    Run      = 1'b0;
    case (state_q)
      S_RST: state_d = nxt_t0;
      S_T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        opcode  = OP_ADD;
        state_d = S_T1;
      end
      S_T1: begin
        Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (MemReady) state_d = S_T2;
      end
      S_T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        if (is_bin || is_md || is_un) state_d = S_T3;
        else if (is_halt)             state_d = S_HALT;
        else                          state_d = nxt_t0;
      end
      S_T3: begin
        Run  = 1'b1;
        Rout = onehot(rb);
        if (is_un) begin
          opcode = op; Zin = 1'b1;
        end else begin
          Yin = 1'b1;
        end
        state_d = S_T4;
      end
      S_T4: begin
        Run = 1'b1;
        if (is_un) begin
          Zlowout = 1'b1; Rin = onehot(ra);
          state_d = nxt_t0;
        end else begin
          Rout = onehot(rc); opcode = op; Zin = 1'b1;
          state_d = S_T5;
        end
      end
      S_T5: begin
        Run = 1'b1; Zlowout = 1'b1;
        if (is_md) begin
          LOin = 1'b1;
          state_d = S_T6;
        end else begin
          Rin = onehot(ra);
          state_d = nxt_t0;
        end
      end
      S_T6: begin
        Run = 1'b1; Zhighout = 1'b1; HIin = 1'b1;
        state_d = nxt_t0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboarded bench: each stimulus cycle queues the expected output bundle,
// a negedge monitor pops and compares it against the live DUT outputs.
module tb_control_sequencer;

  localparam int NREG = 16;

  logic            clock = 1'b0;
  logic            clear = 1'b1;
  logic [31:0]     IR = '0;
  logic            MemReady = 1'b0;
  logic            Stop = 1'b0;
  logic [NREG-1:0] Rin, Rout;
  logic            PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
  logic            Yin, Zin, Zlowout, Zhighout, HIin, LOin, Read;
  logic [4:0]      opcode;
  logic            Run;

  control_sequencer #(.NREG(NREG)) dut (
    .clock(clock), .clear(clear), .IR(IR), .MemReady(MemReady), .Stop(Stop),
    .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .Read(Read), .opcode(opcode), .Run(Run)
  );

  always #5 clock = ~clock;

  // Bundle layout {Rin, Rout, strobes[13:0], opcode, Run}.
  typedef logic [51:0] vec_t;
  typedef struct { vec_t v; string name; } exp_t;

  localparam logic [13:0] S_PCOUT = 14'h2000, S_PCIN  = 14'h1000, S_INCPC  = 14'h0800;
  localparam logic [13:0] S_MARIN = 14'h0400, S_MDRIN = 14'h0200, S_MDROUT = 14'h0100;
  localparam logic [13:0] S_IRIN  = 14'h0080, S_YIN   = 14'h0040, S_ZIN    = 14'h0020;
  localparam logic [13:0] S_ZLO   = 14'h0010, S_ZHI   = 14'h0008, S_HIIN   = 14'h0004;
  localparam logic [13:0] S_LOIN  = 14'h0002, S_READ  = 14'h0001;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t ex(input logic [15:0] rin, input logic [15:0] rout,
                              input logic [13:0] s, input logic [4:0] op, input logic run);
    return {rin, rout, s, op, run};
  endfunction

  vec_t ZERO, T0V, T1V, T2V;

  always @(negedge clock) begin
    exp_t e;
    vec_t act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin,
             Zlowout, Zhighout, HIin, LOin, Read, opcode, Run};
      n_vec++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s @%0t: got Rin=%h Rout=%h strb=%b op=%b run=%b, want Rin=%h Rout=%h strb=%b op=%b run=%b",
                 e.name, $time, act[51:36], act[35:20], act[19:6], act[5:1], act[0],
                 e.v[51:36], e.v[35:20], e.v[19:6], e.v[5:1], e.v[0]);
      end
    end
  end

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic step(input vec_t v, input string name);
    exp_t e;
    e.v = v; e.name = name;
    sb.push_back(e);
    @(posedge clock); #1;
  endtask

  // Fetch with nwait cycles of MemReady low in T1.
  task automatic fetch(input int nwait, input string tag);
    MemReady = (nwait == 0);
    step(T0V, {tag, "_T0"});
    for (int i = 0; i < nwait; i++) begin
      MemReady = 1'b0;
      step(T1V, {tag, "_T1wait"});
    end
    MemReady = 1'b1;
    step(T1V, {tag, "_T1"});
    step(T2V, {tag, "_T2"});
  endtask

  task automatic restart();
    clear = 1'b1;
    step(ZERO, "clear_hold");
    clear = 1'b0;
    step(ZERO, "rst_after_release");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ZERO = '0;
    T0V  = ex(16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 5'b00011, 1'b1);
    T1V  = ex(16'h0, 16'h0, S_ZLO | S_PCIN | S_READ | S_MDRIN, 5'b00000, 1'b1);
    T2V  = ex(16'h0, 16'h0, S_MDROUT | S_IRIN, 5'b00000, 1'b1);

    repeat (2) @(posedge clock);
    #1;
    restart();

    // and R4, R5, R7
    IR = 32'h2A2B8000;
    fetch(0, "and");
    step(ex(16'h0, 16'h0020, S_YIN, 5'b00000, 1'b1), "and_T3");
    step(ex(16'h0, 16'h0080, S_ZIN, 5'b00101, 1'b1), "and_T4");
    step(ex(16'h0010, 16'h0, S_ZLO, 5'b00000, 1'b1), "and_T5");

    // ror R4, R3, R7 with three T1 wait cycles
    IR = 32'h421B8000;
    fetch(3, "ror");
    step(ex(16'h0, 16'h0008, S_YIN, 5'b00000, 1'b1), "ror_T3");
    step(ex(16'h0, 16'h0080, S_ZIN, 5'b01000, 1'b1), "ror_T4");
    step(ex(16'h0010, 16'h0, S_ZLO, 5'b00000, 1'b1), "ror_T5");

    // mul R3, R7 (Ra field = R2, must not be written)
    IR = 32'h791B8000;
    fetch(0, "mul");
    step(ex(16'h0, 16'h0008, S_YIN, 5'b00000, 1'b1), "mul_T3");
    step(ex(16'h0, 16'h0080, S_ZIN, 5'b01111, 1'b1), "mul_T4");
    step(ex(16'h0, 16'h0, S_ZLO | S_LOIN, 5'b00000, 1'b1), "mul_T5");
    step(ex(16'h0, 16'h0, S_ZHI | S_HIIN, 5'b00000, 1'b1), "mul_T6");

    // neg R1, R2
    IR = 32'h88900000;
    fetch(0, "neg");
    step(ex(16'h0, 16'h0004, S_ZIN, 5'b10001, 1'b1), "neg_T3");
    step(ex(16'h0002, 16'h0, S_ZLO, 5'b00000, 1'b1), "neg_T4");

    // nop, then an unlisted code (01100): both return to T0 after T2
    IR = 32'hD0000000;
    fetch(0, "nop");
    IR = 32'h60000000;
    fetch(0, "unlisted");

    // halt: sticky HALT, MemReady ignored, only clear exits
    IR = 32'hD8000000;
    fetch(0, "halt");
    for (int i = 0; i < 4; i++) begin
      MemReady = i[0];
      step(ZERO, "halt_hold");
    end
    restart();

    // Stop during T4 of add R4, R5, R7: write still happens, then HALT
    IR = 32'h1A2B8000;
    fetch(0, "stop");
    step(ex(16'h0, 16'h0020, S_YIN, 5'b00000, 1'b1), "stop_T3");
    Stop = 1'b1;
    step(ex(16'h0, 16'h0080, S_ZIN, 5'b00011, 1'b1), "stop_T4");
    step(ex(16'h0010, 16'h0, S_ZLO, 5'b00000, 1'b1), "stop_T5");
    Stop = 1'b0;
    for (int i = 0; i < 3; i++) step(ZERO, "stop_halt_hold");
    restart();

    // clear raised mid-T4: outputs drop without any clock edge, no Rin pulse
    IR = 32'h2A2B8000;
    fetch(0, "clr");
    step(ex(16'h0, 16'h0020, S_YIN, 5'b00000, 1'b1), "clr_T3");
    clear = 1'b1;
    step(ZERO, "clr_midT4");
    step(ZERO, "clr_held");
    clear = 1'b0;
    step(ZERO, "clr_rst");
    step(T0V, "clr_restart_T0");
    step(T1V, "clr_restart_T1");

    @(negedge clock); #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    if (n_vec == 0) begin
      n_bad++;
      $display("FAIL coverage: no vectors compared, want >0");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad != 0) $display("FAIL summary: %0d miscompares, want 0", n_bad);
    else            $display("PASS");
    $finish;
  end

endmodule
